// File: rtl/mux_arb_reg_pkg.sv
// Shared constants and helpers for the arbitrated output multiplexer.
package mux_arb_reg_pkg;

  // Arbitration mode encodings for prio_mode
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceiling log2; callers clamp the result to at least 1 bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index priority.
module rr_arbiter
  import mux_arb_reg_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             prio_mode,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Scan candidates from last to first so the highest-priority requester is written last
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      if (prio_mode == MODE_FIXED) begin
        idx = off;
      end else begin
        idx = int'(ptr) + off;
        if (idx >= N) idx = idx - N;
      end
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx[SEL_W-1:0];
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel arbitrated multiplexer with a registered valid/ready output stage.
module mux_arb_reg
  import mux_arb_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 2,
  parameter int SEL_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prio_mode,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;

  logic [N-1:0]     w_grant;
  logic [SEL_W-1:0] w_gidx;
  logic             w_gvld;
  logic             w_load;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_ptr_nxt;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .prio_mode (prio_mode),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .grant_vld (w_gvld)
  );

  // Output stage can take a beat when empty or draining; nothing is accepted during reset
  assign w_load   = (!r_out_valid || out_ready) && !rst;
  assign in_ready = w_grant & {N{w_load}};

  // Route the granted channel's data and compute the wrapped next pointer
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
    if (int'(w_gidx) == N - 1) w_ptr_nxt = '0;
    else                       w_ptr_nxt = w_gidx + SEL_W'(1);
  end

  // Output register and round-robin pointer; hold everything while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_gvld) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gidx;
        r_out_valid <= 1'b1;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule
